adc_serial_capture: RTL and testbench

//  Parametrised serial-ADC frame reader; successor to the fixed 12-bit, single-lane AD7276 reader.

---
 rtl/adc_serial_capture.sv | 179 +++++++++++++++++
 tb/tb_adc_serial_capture.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_capture.sv
// Serial ADC frame reader: drives shared csn/sclk and captures N_CH sdata lanes MSB-first.
// Supports continuous or triggered conversion with a quiet gap between frames.
//
// state | meaning
// QUIET | csn/sclk high for QUIET_CYC cycles between frames (also the post-reset state)
// IDLE  | csn/sclk high, waiting for cont or trig
// SHIFT | csn low, sclk toggling, lanes sampled at the end of each sclk-high half
module adc_serial_capture #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 2,
  parameter int TRAIL_BITS = 0,
  parameter int HALF_DIV   = 1,
  parameter int QUIET_CYC  = 4,
  parameter int N_CH       = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cont,
  input  logic                     trig,
  output logic                     adc_csn,
  output logic                     adc_sclk,
  input  logic [N_CH-1:0]          adc_sdata,
  output logic                     busy,
  output logic                     trig_drop,
  output logic                     data_valid,
  output logic [N_CH*DATA_W-1:0]   data,
  output logic                     zero_err
);

  localparam int TOTAL = LEAD_ZEROS + DATA_W + TRAIL_BITS;
  localparam int BIT_W = $clog2(TOTAL + 1);
  localparam int DIV_W = $clog2(HALF_DIV + 1);
  localparam int Q_W   = $clog2(QUIET_CYC + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYC - 1);

  typedef enum logic [1:0] {
    QUIET = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [Q_W-1:0]   q_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             sclk_low;

  logic [N_CH-1:0][DATA_W-1:0] shreg;
  logic                        zacc;

  logic quiet_end;
  logic half_end;
  logic sample;
  logic frame_end;
  logic in_lead;
  logic in_data;

  assign quiet_end = (state == QUIET) && (q_cnt == Q_LAST);
  assign half_end  = (div_cnt == DIV_LAST);
  assign sample    = (state == SHIFT) && !sclk_low && half_end;
  assign frame_end = (state == SHIFT) && sclk_low && half_end && (bit_cnt == BIT_LAST);
  assign in_lead   = int'(bit_cnt) < LEAD_ZEROS;
  assign in_data   = (int'(bit_cnt) >= LEAD_ZEROS) && (int'(bit_cnt) < LEAD_ZEROS + DATA_W);

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= QUIET;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      QUIET: begin
        if (quiet_end) begin
          state_nxt = cont ? SHIFT : IDLE;
        end
      end
      IDLE: begin
        if (cont || trig) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_end) begin
          state_nxt = QUIET;
        end
      end
      default: state_nxt = QUIET;
    endcase
  end

  // pin outputs; sclk idles high and the first half of each period is high
  always_comb begin
    adc_csn  = 1'b1;
    adc_sclk = 1'b1;
    if (state == SHIFT) begin
      adc_csn  = 1'b0;
      adc_sclk = !sclk_low;
    end
  end

  // phase counters, reloaded whenever their phase is not active
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_cnt    <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sclk_low <= 1'b0;
    end else begin
      if ((state == QUIET) && !quiet_end) begin
        q_cnt <= q_cnt + Q_W'(1);
      end else begin
        q_cnt <= '0;
      end

      if (state == SHIFT) begin
        if (half_end) begin
          div_cnt  <= '0;
          sclk_low <= !sclk_low;
          if (sclk_low && !frame_end) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        sclk_low <= 1'b0;
      end
    end
  end

  // capture datapath and status pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg      <= '0;
      zacc       <= 1'b0;
      data       <= '0;
      zero_err   <= 1'b0;
      data_valid <= 1'b0;
      trig_drop  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= frame_end;
      trig_drop  <= trig && !cont && (state != IDLE);
      busy       <= (state_nxt != IDLE);

      if (state != SHIFT) begin
        zacc <= 1'b0;
      end else if (sample && in_lead) begin
        zacc <= zacc | (|adc_sdata);
      end

      if (sample && in_data) begin
        for (int k = 0; k < N_CH; k++) begin
          shreg[k] <= {shreg[k][DATA_W-2:0], adc_sdata[k]};
        end
      end

      // results only move on the data_valid edge so they hold between frames
      if (frame_end) begin
        data     <= shreg;
        zero_err <= zacc;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: table-driven continuous frames plus
// hand-written trigger, cont-drop and mid-frame reset sequences.
module tb_adc_serial_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, cont, trig;
  logic        csn, sclk, busy, trig_drop, data_valid, zero_err;
  logic [0:0]  sdata;
  logic [11:0] data;

  logic        cont2;
  logic        csn2, sclk2, busy2, drop2, valid2, zerr2;
  logic [1:0]  sdata2;
  logic [23:0] data2;

  adc_serial_capture dut (
    .clk(clk), .rstn(rstn), .cont(cont), .trig(trig),
    .adc_csn(csn), .adc_sclk(sclk), .adc_sdata(sdata),
    .busy(busy), .trig_drop(trig_drop), .data_valid(data_valid),
    .data(data), .zero_err(zero_err)
  );

  adc_serial_capture #(.N_CH(2), .HALF_DIV(2)) dut2 (
    .clk(clk), .rstn(rstn), .cont(cont2), .trig(1'b0),
    .adc_csn(csn2), .adc_sclk(sclk2), .adc_sdata(sdata2),
    .busy(busy2), .trig_drop(drop2), .data_valid(valid2),
    .data(data2), .zero_err(zerr2)
  );

  // ADC models: present bit idx of a 14-bit frame word, advance after each sclk fall
  logic [13:0] word0 = '0;
  logic [13:0] w2a = 14'h0123;
  logic [13:0] w2b = 14'h0FED;
  int   idx0 = 0, idx2 = 0;
  logic ps0 = 1'b1, ps2 = 1'b1;

  always @(negedge clk) begin
    if (csn !== 1'b0) idx0 = 0;
    else if (ps0 && !sclk) idx0 = idx0 + 1;
    ps0 = sclk;
    sdata[0] = (idx0 < 14) ? word0[13-idx0] : 1'b0;

    if (csn2 !== 1'b0) idx2 = 0;
    else if (ps2 && !sclk2) idx2 = idx2 + 1;
    ps2 = sclk2;
    sdata2[0] = (idx2 < 14) ? w2a[13-idx2] : 1'b0;
    sdata2[1] = (idx2 < 14) ? w2b[13-idx2] : 1'b0;
  end

  // pin monitor, samples the previous cycle's values on each rising edge
  int   cyc = 0, run0 = 0, last_run0 = 0, run2 = 0, last_run2 = 0, falls2 = 0, last_falls2 = 0;
  logic pm2 = 1'b1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (csn === 1'b0) run0 = run0 + 1;
    else if (run0 != 0) begin last_run0 = run0; run0 = 0; end
    if (csn2 === 1'b0) begin
      run2 = run2 + 1;
      if (pm2 && !sclk2) falls2 = falls2 + 1;
    end else if (run2 != 0) begin
      last_run2 = run2; last_falls2 = falls2; run2 = 0; falls2 = 0;
    end
    pm2 = sclk2;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_valid2(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (valid2 === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_bit(input string name, input int b);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (csn === 1'b0 && idx0 >= b) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [13:0] frame;
    logic [11:0] exp_data;
    logic        exp_zerr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int t_prev, t_now, n_pulse;
    bit bad;
    logic [11:0] cap;

    vecs[0] = '{14'h0A5C, 12'hA5C, 1'b0};
    vecs[1] = '{14'h0FFF, 12'hFFF, 1'b0};
    vecs[2] = '{14'h0000, 12'h000, 1'b0};
    vecs[3] = '{14'h2123, 12'h123, 1'b1};
    vecs[4] = '{14'h1555, 12'h555, 1'b1};
    vecs[5] = '{14'h0800, 12'h800, 1'b0};
    vecs[6] = '{14'h0001, 12'h001, 1'b0};
    vecs[7] = '{14'h3ABC, 12'hABC, 1'b1};
    vecs[8] = '{14'h0A5C, 12'hA5C, 1'b0};

    rstn = 1'b0; cont = 1'b0; cont2 = 1'b0; trig = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(csn), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trig_drop", 32'(trig_drop), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_zero_err", 32'(zero_err), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_data2", 32'(data2), 32'd0);

    // continuous frames from the vector table, 32-cycle period, 28 cycles with csn low
    word0 = vecs[0].frame;
    cont = 1'b1; cont2 = 1'b1; rstn = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 9; i++) begin
      wait_valid($sformatf("v%0d_valid", i), 80);
      t_now = cyc;
      check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_zero_err", i), 32'(zero_err), 32'(vecs[i].exp_zerr));
      if (i > 0) check($sformatf("v%0d_period", i), 32'(t_now - t_prev), 32'd32);
      t_prev = t_now;
      @(negedge clk);
      check($sformatf("v%0d_csn_low", i), 32'(last_run0), 32'd28);
      check($sformatf("v%0d_data_hold", i), 32'(data), 32'(vecs[i].exp_data));
      if (i < 8) word0 = vecs[i+1].frame;
      if (i == 3) begin
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("cont_trig_no_drop", 32'(trig_drop), 32'd0);
      end
    end

    // two lanes, half divider 2: 4-clk sclk, 56-cycle shift, 60-cycle period
    wait_valid2("dual_valid", 150);
    t_now = cyc;
    check("dual_data", 32'(data2), 32'h00FED123);
    check("dual_zero_err", 32'(zerr2), 32'd0);
    @(negedge clk);
    check("dual_csn_low", 32'(last_run2), 32'd56);
    check("dual_sclk_falls", 32'(last_falls2), 32'd14);
    wait_valid2("dual_valid2", 150);
    check("dual_period", 32'(cyc - t_now), 32'd60);
    cont2 = 1'b0;

    // cont dropped mid-frame: frame completes, QUIET, then IDLE
    wait_valid("pre_drop_valid", 80);
    @(negedge clk);
    word0 = 14'h0321;
    wait_bit("drop_bit3", 3);
    cont = 1'b0;
    wait_valid("drop_valid", 80);
    check("drop_data", 32'(data), 32'h321);
    repeat (3) @(negedge clk);
    check("drop_busy_quiet", 32'(busy), 32'd1);
    @(negedge clk);
    check("drop_busy_idle", 32'(busy), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b0 || csn !== 1'b1) bad = 1'b1;
    end
    check("drop_stays_idle", 32'(bad), 32'd0);

    // triggered frame, then a dropped trigger while busy
    word0 = 14'h0ABC;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check("trig_csn_low", 32'(csn), 32'd0);
    check("trig_busy", 32'(busy), 32'd1);
    check("trig_no_drop", 32'(trig_drop), 32'd0);
    repeat (4) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    check("trig_drop_pulse", 32'(trig_drop), 32'd1);
    @(negedge clk);
    check("trig_drop_end", 32'(trig_drop), 32'd0);
    n_pulse = 0; cap = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin n_pulse++; cap = data; end
    end
    check("trig_one_frame", 32'(n_pulse), 32'd1);
    check("trig_data", 32'(cap), 32'hABC);
    check("trig_busy_end", 32'(busy), 32'd0);
    check("trig_csn_end", 32'(csn), 32'd1);

    // reset at bit 7 aborts the frame; restart after 4 quiet cycles
    word0 = 14'h0456;
    cont = 1'b1;
    wait_bit("rst_bit7", 7);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_csn", 32'(csn), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_zero_err", 32'(zero_err), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    rstn = 1'b1;
    t_now = cyc;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", j), 32'(csn), 32'd1);
    end
    @(negedge clk);
    check("post_rst_shift", 32'(csn), 32'd0);
    wait_valid("post_rst_valid", 80);
    check("post_rst_latency", 32'(cyc - t_now), 32'd32);
    check("post_rst_data", 32'(data), 32'h456);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
